// File: rtl/tap_prescaler.sv
// Free-running binary prescaler producing single-cycle tap strobes at CLK/2^(b+1),
// with pause control and a clear request/acknowledge handshake for in-phase restarts.
module tap_prescaler #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NTAPS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic [NTAPS-1:0] taps,
    output logic [WIDTH-1:0] cnt,
    output logic             running
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StPause,
        StClear,
        StWaitRel
    } state_e;

    function automatic int tap_bit(input int i);
        return (i * int'(WIDTH - 1)) / int'(NTAPS - 1);
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [NTAPS-1:0]   taps_q, taps_d;
    logic               ack_q, ack_d;
    logic               run_q, run_d;
    logic               clr_hist_q;
    logic               clr_rise;
    logic [WIDTH-1:0]   cnt_inc;
    logic [NTAPS-1:0]   tap_hit;

    assign clr_rise = clr_req & ~clr_hist_q;
    assign cnt_inc  = cnt_q + WIDTH'(1);

    // A tap fires when the incoming count has bit b set and every lower bit clear.
    for (genvar g = 0; g < int'(NTAPS); g++) begin : g_tap
        localparam int               B    = tap_bit(g);
        localparam logic [WIDTH-1:0] Mask = {WIDTH{1'b1}} >> (WIDTH - 1 - B);
        localparam logic [WIDTH-1:0] Top  = WIDTH'(1) << B;
        assign tap_hit[g] = (cnt_inc & Mask) == Top;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        taps_d  = '0;
        ack_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (clr_rise) begin
                    state_d = StClear;
                end else if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (clr_rise) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (!en) begin
                    state_d = StPause;
                end else begin
                    cnt_d  = cnt_inc;
                    taps_d = tap_hit;
                end
            end
            StPause: begin
                if (clr_rise) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (en) begin
                    state_d = StRun;
                end
            end
            StClear: begin
                cnt_d   = '0;
                ack_d   = 1'b1;
                state_d = StWaitRel;
            end
            StWaitRel: begin
                cnt_d = '0;
                if (!clr_req) begin
                    state_d = en ? StRun : StPause;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        run_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            taps_q     <= '0;
            ack_q      <= 1'b0;
            run_q      <= 1'b0;
            clr_hist_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            taps_q     <= taps_d;
            ack_q      <= ack_d;
            run_q      <= run_d;
            clr_hist_q <= clr_req;
        end
    end

    assign cnt     = cnt_q;
    assign taps    = taps_q;
    assign clr_ack = ack_q;
    assign running = run_q;

endmodule

// File: tb/tb_tap_prescaler.sv
// Self-checking bench for tap_prescaler: WIDTH=8/NTAPS=4 scenarios through a scoreboard queue,
// plus a default-parameter instance whose tap mapping is probed by forcing the count.
module tb_tap_prescaler;

    typedef struct {
        logic       en;
        logic       clr;
        logic [7:0] cnt;
        logic [3:0] taps;
        logic       ack;
        logic       run;
        string      name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr_req;
    logic        clr_ack;
    logic [3:0]  taps;
    logic [7:0]  cnt;
    logic        running;

    logic        en2;
    logic        clr2;
    logic        ack2;
    logic [5:0]  taps2;
    logic [31:0] cnt2;
    logic        run2;

    int          tests = 0;
    int          fails = 0;
    vec_t        exp_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    tap_prescaler #(.WIDTH(8), .NTAPS(4)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr_req (clr_req),
        .clr_ack (clr_ack),
        .taps    (taps),
        .cnt     (cnt),
        .running (running)
    );

    tap_prescaler u_dflt (
        .clk     (clk),
        .rst     (rst),
        .en      (en2),
        .clr_req (clr2),
        .clr_ack (ack2),
        .taps    (taps2),
        .cnt     (cnt2),
        .running (run2)
    );

    function automatic vec_t mk(input logic e, input logic c, input int n, input logic [3:0] t,
                                input logic a, input logic r, input string nm);
        vec_t v;
        v.en = e; v.clr = c; v.cnt = 8'(n); v.taps = t; v.ack = a; v.run = r; v.name = nm;
        return v;
    endfunction

    // Expected strobes for a count value, by modular arithmetic on bits 0,2,4,7.
    function automatic logic [3:0] exp_taps(input int v);
        int bits[4] = '{0, 2, 4, 7};
        logic [3:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k] = ((v % (1 << (bits[k] + 1))) == (1 << bits[k]));
        end
        return r;
    endfunction

    task automatic check_zero(input string nm);
        tests++;
        if (cnt !== 8'd0 || taps !== 4'd0 || clr_ack !== 1'b0 || running !== 1'b0) begin
            fails++;
            $display("FAIL %s: cnt=%0d taps=%b ack=%b run=%b, expected all zero",
                     nm, cnt, taps, clr_ack, running);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        en      = v.en;
        clr_req = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        tests++;
        if (cnt !== e.cnt || taps !== e.taps || clr_ack !== e.ack || running !== e.run) begin
            fails++;
            $display("FAIL %s: got cnt=%0d taps=%b ack=%b run=%b, expected cnt=%0d taps=%b ack=%b run=%b",
                     e.name, cnt, taps, clr_ack, running, e.cnt, e.taps, e.ack, e.run);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] fv;
        int          b;
        rst = 1'b1; en = 1'b0; clr_req = 1'b0; en2 = 1'b1; clr2 = 1'b0;
        #1;
        check_zero("reset_state");
        @(posedge clk);
        #1;
        do_reset();

        // Free run for 300 cycles, including the 255->0 wrap.
        step(mk(1, 0, 0, 4'b0000, 0, 1, "idle_to_run"));
        for (int n = 1; n <= 300; n++) begin
            step(mk(1, 0, n % 256, exp_taps(n % 256), 0, 1, "free_run"));
        end

        // Asynchronous reset from a nonzero running state.
        rst = 1'b1;
        #1;
        check_zero("async_reset_run");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pause at 15, resume into the tap2 strobe at 16.
        step(mk(1, 0, 0, 4'b0000, 0, 1, "idle_to_run2"));
        for (int n = 1; n <= 15; n++) begin
            step(mk(1, 0, n, exp_taps(n), 0, 1, "run_to_15"));
        end
        for (int k = 0; k < 10; k++) begin
            step(mk(0, 0, 15, 4'b0000, 0, 0, "pause_hold"));
        end
        step(mk(1, 0, 15, 4'b0000, 0, 1, "resume_edge"));
        step(mk(1, 0, 16, 4'b0100, 0, 1, "resume_16"));
        for (int n = 17; n <= 100; n++) begin
            step(mk(1, 0, n, exp_taps(n), 0, 1, "run_to_100"));
        end

        // Clear handshake held 20 cycles, then clear racing an en fall.
        tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, "clr_enter"));
        tbl.push_back(mk(1, 1, 0, 4'b0000, 1, 0, "clr_ack"));
        for (int k = 0; k < 18; k++) tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, "clr_wait_rel"));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 1, "clr_release"));
        tbl.push_back(mk(1, 0, 1, 4'b0001, 0, 1, "restart_1"));
        tbl.push_back(mk(1, 0, 2, 4'b0000, 0, 1, "restart_2"));
        tbl.push_back(mk(1, 0, 3, 4'b0001, 0, 1, "restart_3"));
        tbl.push_back(mk(0, 1, 0, 4'b0000, 0, 0, "sim_clear"));
        tbl.push_back(mk(0, 1, 0, 4'b0000, 1, 0, "sim_ack"));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 0, "sim_pause"));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 1, "sim_run"));
        tbl.push_back(mk(1, 0, 1, 4'b0001, 0, 1, "sim_count"));
        tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, "wr_clear"));
        tbl.push_back(mk(1, 1, 0, 4'b0000, 1, 0, "wr_ack"));
        tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, "wr_hold"));
        foreach (tbl[i]) step(tbl[i]);

        // Reset mid-WAIT_REL with clr_req still high: a fresh clear follows.
        rst = 1'b1;
        #1;
        check_zero("async_reset_wait_rel");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(mk(1, 1, 0, 4'b0000, 0, 0, "rr_clear"));
        step(mk(1, 1, 0, 4'b0000, 1, 0, "rr_ack"));
        step(mk(1, 1, 0, 4'b0000, 0, 0, "rr_hold"));
        step(mk(1, 0, 0, 4'b0000, 0, 1, "rr_release"));
        step(mk(1, 0, 1, 4'b0001, 0, 1, "rr_count"));

        // Default mapping 0,6,12,18,24,31: land on 2^b and expect only tap i.
        for (int i = 0; i < 6; i++) begin
            b  = (i * 31) / 5;
            fv = 32'((64'd1 << b) - 64'd1);
            force u_dflt.cnt_q = fv;
            #1;
            release u_dflt.cnt_q;
            @(posedge clk);
            #1;
            tests++;
            if (taps2 !== 6'(1 << i) || cnt2 !== 32'(64'd1 << b)) begin
                fails++;
                $display("FAIL dflt_tap%0d: got cnt=%h taps=%b, expected cnt=%h taps=%b",
                         i, cnt2, taps2, 32'(64'd1 << b), 6'(1 << i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tap_prescaler.md
Name: tap_prescaler

Overview:
- Free-running binary prescaler that generates the `taps` enable vector consumed by downstream stepped counters and dividers.
- Each tap is a single-cycle strobe at CLK/2^(b+1), where b is the tap's counter bit position.
- Adds a pause control and a clear request/acknowledge handshake so software-facing logic can restart all timebases in phase.
- Sits at the top of the sandbox timebase, one instance fanning out to all tap consumers.

Parameters:
- WIDTH, 32, prescaler counter width in bits (>= 2).
- NTAPS, 6, number of tap strobes (>= 2, <= WIDTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low pauses counting and suppresses strobes.
- clr_req  input  1  clear request, level; acted on at its rising edge only.
- clr_ack  output  1  one-cycle acknowledge that a clear has been applied.
- taps  output  NTAPS  registered single-cycle strobes; taps[i] is tied to counter bit tap_bit(i).
- cnt  output  WIDTH  current prescaler count, registered.
- running  output  1  high in RUN state.

Behaviour:
- Tap mapping:
  - tap_bit(i) = (i*(WIDTH-1))/(NTAPS-1), integer division, evaluated at elaboration.
  - Defaults map to bits 0,6,12,18,24,31.
  - With WIDTH=8, NTAPS=4 the bits are 0,2,4,7.
- Reset (async assert, sync release): cnt=0, taps=0, clr_ack=0, running=0, state=IDLE.
- Counter:
  - In RUN, cnt <= cnt+1 every clk.
  - Wraps modulo 2^WIDTH with no overflow flag.
- Strobes:
  - On the same edge that loads a new cnt value v, taps[i] <= 1 iff v[b:0] == 2^b (bit b set, bits below clear), with b = tap_bit(i).
  - Otherwise taps[i] <= 0.
  - Consequences: each strobe is exactly 1 cycle wide with period 2^(b+1) cycles. tap0 is high every other cycle. The top tap (b=WIDTH-1) fires when cnt reaches 2^(WIDTH-1).
  - When cnt is not advancing (any state other than RUN), taps <= 0.
- States:
  - IDLE: entered after reset. Moves to RUN when en=1; no counting.
  - RUN: counting. en=0 -> PAUSE, with cnt frozen from that edge. A clr_req rising edge -> CLEAR, which takes priority over en.
  - PAUSE: cnt held, taps=0. en=1 -> RUN, and counting resumes from the held value with no skipped or duplicated strobe. A clr_req rising edge -> CLEAR.
  - CLEAR: one cycle.
    - cnt <= 0 and taps <= 0; clr_ack <= 1 on the exit edge, so clr_ack is high in the cycle following CLEAR.
    - Next state: WAIT_REL.
  - WAIT_REL: remains until clr_req=0, then goes to RUN if en=1, else PAUSE.
    - cnt is held at 0 until exit.
    - Holding clr_req high never produces a second ack.
- Edge detection: clr_req is edge-detected with a one-register history (reset 0). A request asserted in IDLE is honoured (IDLE -> CLEAR).
- Latency:
  - From a clr_req rise sampled at edge N: CLEAR in cycle N+1, clr_ack high in cycle N+2.
  - After clr_req falls, the first count (cnt=1, tap0 strobe) occurs 1 cycle after the WAIT_REL exit edge.
- Simultaneous events: clr_req rise and en fall in the same cycle -> CLEAR (clear wins). The post-clear state then follows en.
- Reset mid-operation (any state, including mid-handshake): everything returns to reset values immediately. The clr_req history is cleared, so a still-high clr_req after reset is seen as a new rising edge.
- running = (state==RUN), registered.

Test Plan:
- Use WIDTH=8, NTAPS=4 for all scenarios.
- Reset then en=1 for 300 cycles:
  - tap0 strobes on cnt=1,3,5,...
  - tap1 on cnt=4,12,20,...
  - tap2 on cnt=16,48,...
  - tap3 only on cnt=128.
  - Every strobe is 1 cycle wide, and cnt wraps 255->0.
- Pause and resume: run to cnt=15, drop en for 10 cycles.
  - cnt holds 15 and taps=0 throughout the pause.
  - After en=1, cnt=16 with taps[2]=1 and taps[1]=0 on the same edge.
- Clear handshake: raise clr_req at cnt=100 and hold for 20 cycles.
  - cnt=0 in the next cycle; clr_ack is exactly one cycle wide, 2 cycles after the request.
  - cnt stays 0 while clr_req is high; counting restarts at 1 after release.
- Simultaneous clr_req rise and en fall:
  - State goes CLEAR -> WAIT_REL -> PAUSE with cnt=0.
  - No strobes until en=1.
- Async reset asserted mid-WAIT_REL with clr_req still high:
  - All outputs go to 0 without waiting for a clock edge.
  - After release with en=1, the held clr_req produces a fresh CLEAR and one clr_ack.
- Default parameters: check the tap bit mapping 0,6,12,18,24,31 by forcing cnt near 2^24-1 and observing a taps[4] strobe.
